bresen_pixel_writer: RTL and testbench

Consumer end of the line generator's pixel-address stream. Accepts linear framebuffer addresses (y*640 + x, 19 bits) plus a draw colour, and buffers them in a small FIFO. Drains the FIFO to the framebuffer memory port with a write/ack handshake. Throttles the generator through `stop`, and reports completion of a primitive once its last pixel is committed.

---
 rtl/bresen_pixel_writer.sv | 140 ++++++++++++++
 tb/tb_bresen_pixel_writer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bresen_pixel_writer.sv
// bresen_pixel_writer: buffers linear pixel addresses from the line generator in a
// small FIFO, drains them to the framebuffer with a write/ack handshake, throttles
// the generator via stop, and pulses drawDone once a primitive is fully committed.
module bresen_pixel_writer #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int STOP_THRESH = 6,
    parameter int FB_SIZE     = 307200
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              pixel_valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] color,
    input  logic              lineDone,
    output logic              stop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    input  logic              mem_ack,
    output logic              drawDone,
    output logic [7:0]        drop_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_SIZE);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  THRESH_C = CNT_W'(STOP_THRESH);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [ADDR_W-1:0] last_addr;
    logic              last_addr_valid;
    logic              pending_done;
    logic              fifo_empty;
    logic              fifo_full;
    logic              in_range;
    logic              is_dup;
    logic              push;
    logic              pop;
    logic              reject;
    logic              done_fire;

    // Drop counter never wraps; a stuck 255 still tells software pixels were lost.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    assign in_range   = (address < FB_LIMIT);
    // A stalled generator repeats its last output; only the first copy is real.
    assign is_dup     = last_addr_valid && (address == last_addr);
    // Full is judged on the pre-edge count, so a same-edge pop does not make room.
    assign push       = pixel_valid && in_range && !fifo_full && !is_dup;
    assign reject     = pixel_valid && (!in_range || fifo_full);
    assign done_fire  = pending_done && fifo_empty && (state_q == IDLE) && !push;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: leave ISSUE only when the ack finds nothing else to send
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = ISSUE;
            ISSUE:   if (mem_ack && fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: write request follows ISSUE; pop on start or on ack with data waiting
    always_comb begin
        mem_wen = (state_q == ISSUE);
        pop     = !fifo_empty && ((state_q == IDLE) || mem_ack);
    end

    // FIFO storage, written at the tail on every accepted pixel
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= address;
            fifo_data[wr_ptr] <= color;
        end
    end

    // Write port registers, loaded from the FIFO head on each pop and held until ack
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (pop) begin
            mem_addr  <= fifo_addr[rd_ptr];
            mem_wdata <= fifo_data[rd_ptr];
        end
    end

    // Pointers, occupancy, backpressure, duplicate filter, drops and completion tracking
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            stop            <= 1'b0;
            drop_count      <= '0;
            last_addr       <= '0;
            last_addr_valid <= 1'b0;
            pending_done    <= 1'b0;
            drawDone        <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_next;
            stop     <= (count_next >= THRESH_C);
            drawDone <= done_fire;
            if (reject) drop_count <= sat_inc8(drop_count);
            if (push) last_addr <= address;
            // done_fire implies no push, so the two flag updates never collide
            if (done_fire) begin
                pending_done    <= 1'b0;
                last_addr_valid <= 1'b0;
            end else begin
                if (lineDone) pending_done <= 1'b1;
                if (push)     last_addr_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bresen_pixel_writer.sv
// Testbench for bresen_pixel_writer: scenario tasks plus a randomized run, all
// compared against a queue-based reference model of the pixel writer.
module tb_bresen_pixel_writer;
    logic        tb_clk;
    logic        n_rst;
    logic        pixel_valid;
    logic [18:0] address;
    logic [7:0]  color;
    logic        lineDone;
    logic        stop;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic        mem_ack;
    logic        drawDone;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [18:0] mq_addr[$];
    logic [7:0]  mq_col[$];
    bit          m_busy;
    logic [18:0] m_cur_addr;
    logic [7:0]  m_cur_col;
    bit          m_lav;
    logic [18:0] m_last;
    bit          m_pend;
    logic [7:0]  m_drops;
    bit          m_stop;
    bit          m_done;
    // Observed commits (write accepted by memory)
    int          n_commits;
    logic [18:0] last_commit;

    bresen_pixel_writer dut (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .pixel_valid(pixel_valid),
        .address    (address),
        .color      (color),
        .lineDone   (lineDone),
        .stop       (stop),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_ack    (mem_ack),
        .drawDone   (drawDone),
        .drop_count (drop_count)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    task automatic model_clear();
        mq_addr.delete();
        mq_col.delete();
        m_busy = 0; m_cur_addr = '0; m_cur_col = '0;
        m_lav = 0; m_last = '0; m_pend = 0;
        m_drops = '0; m_stop = 0; m_done = 0;
    endtask

    task automatic do_reset();
        n_rst = 1'b0; pixel_valid = 1'b0; address = '0; color = '0;
        lineDone = 1'b0; mem_ack = 1'b0;
        @(posedge tb_clk);
        model_clear();
        #1;
        n_rst = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the model over the edge, settle 1 time unit.
    task automatic step(input bit v, input logic [18:0] a, input logic [7:0] c,
                        input bit ld, input bit ack);
        bit push, pop, fire, full;
        pixel_valid = v; address = a; color = c; lineDone = ld; mem_ack = ack;
        #1;
        if (mem_wen && ack) begin
            n_commits++;
            last_commit = mem_addr;
        end
        @(posedge tb_clk);
        full = (mq_addr.size() == 8);
        push = v && (a < 19'd307200) && !full && !(m_lav && a == m_last);
        pop  = (mq_addr.size() > 0) && (!m_busy || ack);
        fire = m_pend && (mq_addr.size() == 0) && !m_busy && !push;
        if (v && ((a >= 19'd307200) || full) && m_drops != 8'd255) m_drops++;
        if (pop) begin
            m_cur_addr = mq_addr.pop_front();
            m_cur_col  = mq_col.pop_front();
            m_busy     = 1;
        end else if (m_busy && ack) begin
            m_busy = 0;
        end
        if (push) begin
            mq_addr.push_back(a);
            mq_col.push_back(c);
            m_last = a;
            m_lav  = 1;
        end
        if (fire) begin
            m_pend = 0;
            m_lav  = 0;
        end else if (ld) begin
            m_pend = 1;
        end
        m_done = fire;
        m_stop = (mq_addr.size() >= 6);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({stop, mem_wen, drawDone, drop_count, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got stop=%b wen=%b done=%b drops=%0d addr=%0d data=%h want all 0",
                     stop, mem_wen, drawDone, drop_count, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_stream();
        logic [18:0] addrs[3];
        bit          exp_wen[6];
        logic [18:0] exp_addr[6];
        addrs = '{19'd0, 19'd641, 19'd1282};
        exp_wen  = '{0, 1, 1, 1, 0, 0};
        exp_addr = '{19'd0, 19'd0, 19'd641, 19'd1282, 19'd0, 19'd0};
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step(1, addrs[i], 8'hFF, 0, 1);
            else       step(0, 19'd0, 8'h00, 0, 1);
            checks++;
            if (mem_wen !== exp_wen[i]) begin
                errors++;
                $display("FAIL stream_wen[%0d]: got %b want %b", i, mem_wen, exp_wen[i]);
            end
            if (exp_wen[i]) begin
                checks++;
                if (mem_addr !== exp_addr[i] || mem_wdata !== 8'hFF) begin
                    errors++;
                    $display("FAIL stream_addr[%0d]: got %0d/%h want %0d/ff", i, mem_addr, mem_wdata, exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d0;
        int         c0;
        int         guard;
        d0 = drop_count;
        c0 = n_commits;
        // one write in flight and stalled, then 10 more distinct pixels
        step(1, 19'd5000, 8'h10, 0, 0);
        step(0, 19'd0, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 19'd5001 + 19'(i), 8'h20 + 8'(i), 0, 0);
            checks++;
            if ({mem_wen, stop, drop_count} !== {m_busy, m_stop, m_drops}) begin
                errors++;
                $display("FAIL bp_fill[%0d]: got wen=%b stop=%b drops=%0d want wen=%b stop=%b drops=%0d",
                         i, mem_wen, stop, drop_count, m_busy, m_stop, m_drops);
            end
        end
        checks++;
        if (drop_count !== d0 + 8'd2) begin
            errors++;
            $display("FAIL bp_drops: got %0d want %0d", drop_count, d0 + 8'd2);
        end
        guard = 0;
        while ((mem_wen || mq_addr.size() > 0) && guard < 40) begin
            step(0, 19'd0, 8'h00, 0, 1);
            guard++;
            checks++;
            if ({mem_wen, stop} !== {m_busy, m_stop} ||
                (m_busy && {mem_addr, mem_wdata} !== {m_cur_addr, m_cur_col})) begin
                errors++;
                $display("FAIL bp_drain: got wen=%b stop=%b addr=%0d data=%h want wen=%b stop=%b addr=%0d data=%h",
                         mem_wen, stop, mem_addr, mem_wdata, m_busy, m_stop, m_cur_addr, m_cur_col);
            end
        end
        checks++;
        if (n_commits - c0 != 9 || last_commit !== 19'd5008) begin
            errors++;
            $display("FAIL bp_commits: got %0d last=%0d want 9 last=5008", n_commits - c0, last_commit);
        end
    endtask

    task automatic test_range();
        logic [7:0] d0;
        int         c0;
        d0 = drop_count;
        c0 = n_commits;
        step(1, 19'd307200, 8'h33, 0, 1);
        step(1, 19'd524287, 8'h34, 0, 1);
        step(1, 19'd307199, 8'h35, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 19'd0, 8'h00, 0, 1);
        checks++;
        if (drop_count !== d0 + 8'd2) begin
            errors++;
            $display("FAIL range_drops: got %0d want %0d", drop_count, d0 + 8'd2);
        end
        checks++;
        if (n_commits - c0 != 1 || last_commit !== 19'd307199) begin
            errors++;
            $display("FAIL range_commit: got %0d writes last=%0d want 1 last=307199", n_commits - c0, last_commit);
        end
    endtask

    task automatic test_duplicate();
        logic [7:0] d0;
        int         c0;
        d0 = drop_count;
        c0 = n_commits;
        for (int i = 0; i < 4; i++) step(1, 19'd1000, 8'h44, 0, 1);
        step(1, 19'd1001, 8'h45, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 19'd0, 8'h00, 0, 1);
        checks++;
        if (n_commits - c0 != 2 || last_commit !== 19'd1001 || drop_count !== d0) begin
            errors++;
            $display("FAIL dup_writes: got %0d writes last=%0d drops=%0d want 2 last=1001 drops=%0d",
                     n_commits - c0, last_commit, drop_count, d0);
        end
    endtask

    task automatic test_line_done();
        int c0;
        int hold;
        int pulses;
        int guard;
        bit ack;
        c0 = n_commits;
        hold = 0;
        pulses = 0;
        for (guard = 0; guard < 40; guard++) begin
            ack = mem_wen && (hold >= 2);
            if (guard < 3) step(1, 19'd2000 + 19'(guard), 8'h50, guard == 2, ack);
            else           step(0, 19'd0, 8'h00, 0, ack);
            if (ack) hold = 0;
            else if (mem_wen) hold++;
            checks++;
            if ({mem_wen, drawDone} !== {m_busy, m_done}) begin
                errors++;
                $display("FAIL ld_cycle[%0d]: got wen=%b done=%b want wen=%b done=%b",
                         guard, mem_wen, drawDone, m_busy, m_done);
            end
            if (drawDone) begin
                pulses++;
                checks++;
                if (n_commits - c0 != 3) begin
                    errors++;
                    $display("FAIL ld_early: drawDone after %0d writes want 3", n_commits - c0);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ld_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_midwrite();
        for (int i = 0; i < 6; i++) step(1, 19'd3000 + 19'(i), 8'h60, 0, 0);
        checks++;
        if (mem_wen !== 1'b1 || mq_addr.size() != 5) begin
            errors++;
            $display("FAIL rst_setup: got wen=%b queued=%0d want wen=1 queued=5", mem_wen, mq_addr.size());
        end
        do_reset();
        checks++;
        if ({stop, mem_wen, drawDone, drop_count, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got stop=%b wen=%b done=%b drops=%0d addr=%0d want all 0",
                     stop, mem_wen, drawDone, drop_count, mem_addr);
        end
        step(0, 19'd0, 8'h00, 0, 1);
        checks++;
        if (mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL rst_fifo_empty: got wen=%b want 0", mem_wen);
        end
        step(0, 19'd0, 8'h00, 1, 0);
        checks++;
        if (drawDone !== 1'b0) begin
            errors++;
            $display("FAIL empty_done_1: got %b want 0", drawDone);
        end
        step(0, 19'd0, 8'h00, 0, 0);
        checks++;
        if (drawDone !== 1'b1) begin
            errors++;
            $display("FAIL empty_done_2: got %b want 1", drawDone);
        end
        step(0, 19'd0, 8'h00, 0, 0);
        checks++;
        if (drawDone !== 1'b0) begin
            errors++;
            $display("FAIL empty_done_3: got %b want 0", drawDone);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) step(1, 19'd400000, 8'h00, 0, 1);
        checks++;
        if (drop_count !== 8'd255) begin
            errors++;
            $display("FAIL drop_saturate: got %0d want 255", drop_count);
        end
    endtask

    task automatic test_random();
        bit          v;
        bit          ld;
        bit          ack;
        logic [18:0] a;
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 19) == 0);
            ack = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) a = 19'd307200 + 19'($urandom_range(0, 3));
            else                            a = 19'd7000 + 19'($urandom_range(0, 5));
            step(v, a, 8'($urandom), ld, ack);
            checks++;
            if ({mem_wen, stop, drawDone, drop_count} !== {m_busy, m_stop, m_done, m_drops}) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got wen=%b stop=%b done=%b drops=%0d want wen=%b stop=%b done=%b drops=%0d",
                         i, mem_wen, stop, drawDone, drop_count, m_busy, m_stop, m_done, m_drops);
            end
            if (m_busy) begin
                checks++;
                if ({mem_addr, mem_wdata} !== {m_cur_addr, m_cur_col}) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got %0d/%h want %0d/%h",
                             i, mem_addr, mem_wdata, m_cur_addr, m_cur_col);
                end
            end
        end
    endtask

    initial begin
        n_commits = 0;
        last_commit = '0;
        model_clear();
        test_reset();
        test_stream();
        test_backpressure();
        test_range();
        test_duplicate();
        test_line_done();
        test_reset_midwrite();
        test_saturation();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
